// File: rtl/hbridge_drive_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hbridge_pkg                                                              |
// | Drive-state encodings and H-bridge command words for the rover arbiter. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package hbridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FWD   = 3'd1,
    REV   = 3'd2,
    DEAD  = 3'd3,
    BLOCK = 3'd4
  } driveState_t;

  localparam logic [3:0] c_CMD_FWD = 4'b0110;
  localparam logic [3:0] c_CMD_REV = 4'b1001;
  localparam logic [3:0] c_CMD_OFF = 4'b0000;

  // Direction bit 1 means forward.
  function automatic driveState_t driveFor(input logic dir);
    return dir ? FWD : REV;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hbridge_drive_arbiter_obstacle_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obstacle_debounce                                                        |
// | ORs active-high obstacle hits and debounces the result into one flag.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module obstacle_debounce #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int N_IN         = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_IN-1:0] rawBits,
  output logic            flag
);

  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic               w_raw;
  logic [c_CNT_W-1:0] r_cnt;

  assign w_raw = |rawBits;

  // The flag flips on the edge that sees the Nth consecutive disagreeing sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag  <= 1'b0;
      r_cnt <= '0;
    end else if (w_raw == flag) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      flag  <= w_raw;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hbridge_drive_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hbridge_drive_arbiter                                                    |
// | Routes move requests to the H-bridge word with obstacle blocking and a   |
// | dead-time brake on reversal. Define IR_SENSE_EN to add the IR sensors.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hbridge_drive_arbiter
  import hbridge_pkg::*;
#(
  parameter int         N_SENS       = 4,
  parameter logic       SENS_ACT_LVL = 1'b0,
  parameter int         DEBOUNCE_CYC = 16,
  parameter int         DEADTIME_CYC = 50000,
  parameter logic [3:0] CMD_FWD      = c_CMD_FWD,
  parameter logic [3:0] CMD_REV      = c_CMD_REV,
  parameter logic [3:0] CMD_OFF      = c_CMD_OFF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          isMoving_isItForward,
  input  logic                canMove,
  input  logic [2*N_SENS-1:0] sensIP,
  input  logic [1:0]          sensIR_frontBack,
  output logic [3:0]          movingDirection_finalDecision,
  output logic [2:0]          drive_state,
  output logic [1:0]          obstacle_frontBack
);

  localparam int                  c_DEAD_W    = $clog2(DEADTIME_CYC + 1);
  localparam logic [c_DEAD_W-1:0] c_DEAD_LAST = c_DEAD_W'(DEADTIME_CYC - 1);
  localparam logic [c_DEAD_W-1:0] c_DEAD_MAX  = c_DEAD_W'(DEADTIME_CYC);
  localparam logic [c_DEAD_W-1:0] c_DEAD_ONE  = c_DEAD_W'(1);

  logic [N_SENS:0]     w_frontHits, w_backHits;
  logic                w_frontFlag, w_backFlag;
  logic                w_reqOk, w_reqDir, w_blocked, w_deadDone;
  driveState_t         r_state, w_nextState;
  logic                r_lastDir;
  logic [c_DEAD_W-1:0] r_deadCnt;
  logic [3:0]          r_cmd;

`ifdef IR_SENSE_EN
  assign w_frontHits = {sensIR_frontBack[0] == SENS_ACT_LVL,
                        sensIP[N_SENS-1:0] ~^ {N_SENS{SENS_ACT_LVL}}};
  assign w_backHits  = {sensIR_frontBack[1] == SENS_ACT_LVL,
                        sensIP[2*N_SENS-1:N_SENS] ~^ {N_SENS{SENS_ACT_LVL}}};
`else
  logic w_irUnused;
  assign w_irUnused  = ^sensIR_frontBack;
  assign w_frontHits = {1'b0, sensIP[N_SENS-1:0] ~^ {N_SENS{SENS_ACT_LVL}}};
  assign w_backHits  = {1'b0, sensIP[2*N_SENS-1:N_SENS] ~^ {N_SENS{SENS_ACT_LVL}}};
`endif

  obstacle_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .N_IN(N_SENS + 1)) u_frontDebounce (
    .clock  (clock),
    .reset  (reset),
    .rawBits(w_frontHits),
    .flag   (w_frontFlag)
  );

  obstacle_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .N_IN(N_SENS + 1)) u_backDebounce (
    .clock  (clock),
    .reset  (reset),
    .rawBits(w_backHits),
    .flag   (w_backFlag)
  );

  assign w_reqOk    = canMove & isMoving_isItForward[0];
  assign w_reqDir   = isMoving_isItForward[1];
  assign w_blocked  = w_reqDir ? w_frontFlag : w_backFlag;
  assign w_deadDone = (r_deadCnt == c_DEAD_LAST);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_reqOk) begin
          if (w_blocked)                   w_nextState = BLOCK;
          else if (w_reqDir != r_lastDir)  w_nextState = DEAD;
          else                             w_nextState = driveFor(w_reqDir);
        end
      end
      FWD: begin
        if (!w_reqOk)         w_nextState = IDLE;
        else if (!w_reqDir)   w_nextState = DEAD;
        else if (w_frontFlag) w_nextState = BLOCK;
      end
      REV: begin
        if (!w_reqOk)        w_nextState = IDLE;
        else if (w_reqDir)   w_nextState = DEAD;
        else if (w_backFlag) w_nextState = BLOCK;
      end
      DEAD: begin
        if (!w_reqOk)        w_nextState = IDLE;
        else if (w_deadDone) w_nextState = w_blocked ? BLOCK : driveFor(w_reqDir);
      end
      BLOCK: begin
        // A reversal out of BLOCK still pays the full dead time.
        if (!w_reqOk)                    w_nextState = IDLE;
        else if (w_reqDir != r_lastDir)  w_nextState = DEAD;
        else if (!w_blocked)             w_nextState = driveFor(w_reqDir);
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cmd     <= CMD_OFF;
      r_lastDir <= 1'b1;
      r_deadCnt <= '0;
    end else begin
      r_state <= w_nextState;
      r_cmd   <= (w_nextState == FWD) ? CMD_FWD :
                 (w_nextState == REV) ? CMD_REV : CMD_OFF;

      if (w_nextState == FWD)                         r_lastDir <= 1'b1;
      else if (w_nextState == REV)                    r_lastDir <= 1'b0;
      else if (r_state == DEAD && w_reqOk && w_deadDone) r_lastDir <= w_reqDir;

      if (r_state == DEAD && w_nextState == DEAD)
        r_deadCnt <= (r_deadCnt == c_DEAD_MAX) ? r_deadCnt : r_deadCnt + c_DEAD_ONE;
      else
        r_deadCnt <= '0;
    end
  end

  assign movingDirection_finalDecision = r_cmd;
  assign drive_state                   = r_state;
  assign obstacle_frontBack            = {w_backFlag, w_frontFlag};

endmodule
`default_nettype wire

// File: tb/tb_hbridge_drive_arbiter.sv
`default_nettype none
// Scoreboard bench for hbridge_drive_arbiter: stimulus queues expected
// {cmd, state, flags} per cycle; the monitor checks them on the falling edge.
module tb_hbridge_drive_arbiter;

  localparam logic [3:0] OFF_W = 4'b0000;
  localparam logic [3:0] FWD_W = 4'b0110;
  localparam logic [3:0] REV_W = 4'b1001;
  localparam logic [2:0] S_IDLE = 3'd0, S_FWD = 3'd1, S_REV = 3'd2, S_DEAD = 3'd3, S_BLOCK = 3'd4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] move;
  logic       canMove;
  logic [7:0] sensIP;
  logic [1:0] sensIR;
  logic [3:0] cmdOut;
  logic [2:0] stateOut;
  logic [1:0] flagsOut;

  int tests = 0;
  int fails = 0;
  logic [8:0] expQ[$];
  string      nameQ[$];

  always #5 clock = ~clock;

  hbridge_drive_arbiter #(
    .N_SENS(4), .SENS_ACT_LVL(1'b0), .DEBOUNCE_CYC(4), .DEADTIME_CYC(8)
  ) dut (
    .clock                        (clock),
    .reset                        (reset),
    .isMoving_isItForward         (move),
    .canMove                      (canMove),
    .sensIP                       (sensIP),
    .sensIR_frontBack             (sensIR),
    .movingDirection_finalDecision(cmdOut),
    .drive_state                  (stateOut),
    .obstacle_frontBack           (flagsOut)
  );

  task automatic push(input logic [3:0] c, input logic [2:0] s, input logic [1:0] f, input string n);
    expQ.push_back({c, s, f});
    nameQ.push_back(n);
  endtask

  task automatic ticks(input int count, input logic [3:0] c, input logic [2:0] s,
                       input logic [1:0] f, input string n);
    for (int i = 0; i < count; i++) begin
      @(posedge clock);
      #1;
      push(c, s, f, n);
    end
  endtask

  // Reset raised mid-cycle; the check lands before the next rising edge.
  task automatic resetMid(input string n);
    @(posedge clock);
    #1;
    reset = 1'b1;
    push(OFF_W, S_IDLE, 2'b00, n);
  endtask

  initial begin : monitor
    logic [8:0] e;
    string      n;
    logic [3:0] prevCmd;
    prevCmd = OFF_W;
    forever begin
      @(negedge clock);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        tests++;
        if ({cmdOut, stateOut, flagsOut} !== e) begin
          fails++;
          $display("FAIL %s: got cmd=%b state=%0d flags=%b, want cmd=%b state=%0d flags=%b",
                   n, cmdOut, stateOut, flagsOut, e[8:5], e[4:2], e[1:0]);
        end
      end
      tests++;
      if ((prevCmd == FWD_W && cmdOut == REV_W) || (prevCmd == REV_W && cmdOut == FWD_W)) begin
        fails++;
        $display("FAIL no_deadtime: got %b then %b, want OFF between directions", prevCmd, cmdOut);
      end
      prevCmd = cmdOut;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    reset = 1'b1; canMove = 1'b1; move = 2'b11; sensIP = 8'hFF; sensIR = 2'b11;
    ticks(2, OFF_W, S_IDLE, 2'b00, "reset_state");
    reset = 1'b0;
    ticks(1, FWD_W, S_FWD, 2'b00, "start_fwd");
    ticks(1, FWD_W, S_FWD, 2'b00, "fwd_hold");

    // Short glitches on a front sensor never reach the debounce threshold.
    sensIP = 8'hFD; ticks(3, FWD_W, S_FWD, 2'b00, "glitch_a");
    sensIP = 8'hFF; ticks(1, FWD_W, S_FWD, 2'b00, "glitch_gap");
    sensIP = 8'hFD; ticks(3, FWD_W, S_FWD, 2'b00, "glitch_b");
    sensIP = 8'hFF; ticks(2, FWD_W, S_FWD, 2'b00, "glitch_done");

    // Front obstacle held long enough to block, then released.
    sensIP = 8'hFB;
    ticks(3, FWD_W, S_FWD, 2'b00, "front_pending");
    ticks(1, FWD_W, S_FWD, 2'b01, "front_flag_set");
    ticks(2, OFF_W, S_BLOCK, 2'b01, "front_block");
    sensIP = 8'hFF;
    ticks(3, OFF_W, S_BLOCK, 2'b01, "release_pending");
    ticks(1, OFF_W, S_BLOCK, 2'b00, "front_flag_clr");
    ticks(1, FWD_W, S_FWD, 2'b00, "resume_fwd");

    // Forward to reverse: exactly eight OFF cycles.
    move = 2'b01;
    ticks(8, OFF_W, S_DEAD, 2'b00, "dead_to_rev");
    ticks(2, REV_W, S_REV, 2'b00, "rev_drive");

    // Abort dead time; last direction stays reverse so a full dead time reruns.
    move = 2'b11;
    ticks(3, OFF_W, S_DEAD, 2'b00, "dead_to_fwd");
    canMove = 1'b0;
    ticks(2, OFF_W, S_IDLE, 2'b00, "dead_abort");
    canMove = 1'b1;
    ticks(8, OFF_W, S_DEAD, 2'b00, "dead_restart");
    ticks(1, FWD_W, S_FWD, 2'b00, "fwd_after_dead");

    // Request toggles back mid dead time; it still completes.
    move = 2'b01;
    ticks(2, OFF_W, S_DEAD, 2'b00, "toggle_dead_a");
    move = 2'b11;
    ticks(6, OFF_W, S_DEAD, 2'b00, "toggle_dead_b");
    ticks(1, FWD_W, S_FWD, 2'b00, "fwd_after_toggle");

    // Reverse, build a back flag, then reset asynchronously.
    move = 2'b01;
    ticks(8, OFF_W, S_DEAD, 2'b00, "dead_to_rev2");
    ticks(1, REV_W, S_REV, 2'b00, "rev_drive2");
    sensIP = 8'hDF;
    ticks(3, REV_W, S_REV, 2'b00, "back_pending");
    ticks(1, REV_W, S_REV, 2'b10, "back_flag_set");
    resetMid("async_reset");
    sensIP = 8'hFF;
    ticks(1, OFF_W, S_IDLE, 2'b00, "held_reset");
    reset = 1'b0;
    ticks(8, OFF_W, S_DEAD, 2'b00, "dead_after_reset");
    ticks(1, REV_W, S_REV, 2'b00, "rev_after_reset");

    sensIR = 2'b01;
`ifdef IR_SENSE_EN
    ticks(3, REV_W, S_REV, 2'b00, "ir_pending");
    ticks(1, REV_W, S_REV, 2'b10, "ir_flag_set");
    ticks(1, OFF_W, S_BLOCK, 2'b10, "ir_block");
`else
    ticks(5, REV_W, S_REV, 2'b00, "ir_ignored");
`endif
    sensIR = 2'b11;

    @(negedge clock);
    #1;
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
